multicycle_seq: RTL and testbench
=================================

Name: multicycle_seq

Overview:
- Multi-cycle sequencing controller for the processor datapath (PC, instruction register, register file, ALU, data memory).
- Replaces single-cycle combinational control with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives write enables and mux selects, and waits on ready handshakes from instruction and data memory.
- Counts retired instructions and halts on illegal opcode or memory timeout.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- TIMEOUT, 16, maximum wait cycles for a memory ready; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  in IDLE, begin execution.
- halt_req  in  1  stop at the next instruction boundary.
- opcode  in  6  instruction[31:26] from the IR; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_rd  out  1  data memory read request.
- dmem_wr  out  1  data memory write request.
- pc_we  out  1  PC write enable.
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- ir_we  out  1  instruction register write enable.
- reg_we  out  1  register file write enable.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback source is memory.
- alu_src  out  1  ALU B input is the immediate.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- busy  out  1  not in IDLE or HALT.
- halted  out  1  in HALT state.
- err_illegal  out  1  sticky; set when HALT is caused by an illegal opcode.
- err_timeout  out  1  sticky; set when HALT is caused by a memory timeout.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - All outputs 0, retired = 0, wait counter = 0.
- Control outputs are Moore/Mealy decodes of the registered state; no output is registered separately.
- IDLE: start=1 -> FETCH on the next edge.
- FETCH: imem_req=1.
  - imem_ready=1 that cycle: ir_we=1, pc_we=1, pc_src=00 -> DECODE.
  - Otherwise: stay, wait counter +1.
- DECODE (1 cycle): classify opcode.
  - Legal opcodes: 0x00 R-type, 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j.
  - Any other opcode -> HALT with err_illegal=1.
- EXEC:
  - R-type: alu_op=10, alu_src=0 -> WB.
  - addi / lw / sw: alu_op=00, alu_src=1; addi -> WB, lw/sw -> MEM.
  - beq: alu_op=01; pc_we=zero, pc_src=01 -> retire.
  - bne: alu_op=01; pc_we=!zero, pc_src=01 -> retire.
  - j: pc_we=1, pc_src=10 -> retire.
- MEM: alu_src=1, alu_op=00 held; dmem_rd=1 for lw, dmem_wr=1 for sw, held until dmem_ready.
  - On ready: lw -> WB; sw -> retire.
- WB (1 cycle): reg_we=1.
  - R-type: reg_dst=1, mem_to_reg=0.
  - addi: reg_dst=0, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
  - Then -> retire.
- Retire (the transition out of the final state of an instruction):
  - retired increments, wrapping modulo 2^CNT_W.
  - halt_req=1 -> IDLE; otherwise -> FETCH.
- Latency with zero-wait memory:
  - R-type / addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq / bne / j: 3 cycles.
- Wait counter:
  - Clears on entry to FETCH or MEM and on every ready.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 while ready=0 -> HALT, err_timeout=1, all requests dropped.
  - A ready arriving on that same cycle wins (no timeout).
- HALT: all control outputs 0, halted=1; leaves only on reset. start is ignored.
- halt_req outside the retire boundary: ignored until retire; no pulse memory is required, so halt_req must be held by the requester.
- start while busy: ignored.
- Reset mid-access: state returns to IDLE immediately; requests deassert asynchronously.

Decomposition:
- Shared package holds:
  - State encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT).
  - Opcode constants.
  - alu_op codes and pc_src codes.
- One sub-module, mem_wait_timer: wait counter plus timeout compare, instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset, start, R-type (opcode 0x00) with imem_ready=1 always -> FETCH/DECODE/EXEC/WB in 4 cycles; reg_we=1 for 1 cycle with reg_dst=1; retired=1.
- lw (0x23) with dmem_ready delayed 3 cycles -> dmem_rd held 4 cycles; then WB with mem_to_reg=1; 8 cycles total; retired increments once.
- beq (0x04) with zero=1 -> pc_we=1, pc_src=01 in EXEC; bne (0x05) with zero=1 -> pc_we=0; each takes 3 cycles.
- Opcode 0x3F -> HALT after DECODE; err_illegal=1, halted=1, busy=0; later start pulses have no effect until rst_n is pulsed.
- TIMEOUT=4, sw with dmem_ready never asserted -> after 4 MEM cycles: HALT, err_timeout=1, dmem_wr=0; retired unchanged.
- halt_req held during j (0x02) -> IDLE after EXEC; retired=1; a new start pulse resumes at FETCH.

Source files
------------

// File: rtl/multicycle_seq_pkg.sv
//------------------------------------------------------------------------------
// multicycle_seq_pkg
// Shared state encoding, opcode constants and control codes for the sequencer.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package multicycle_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CL_RTYPE   = 3'd0,
        CL_ADDI    = 3'd1,
        CL_LW      = 3'd2,
        CL_SW      = 3'd3,
        CL_BEQ     = 3'd4,
        CL_BNE     = 3'd5,
        CL_J       = 3'd6,
        CL_ILLEGAL = 3'd7
    } iclass_e;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_J     = 6'h02;

    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_SUB   = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT = 2'b10;

    localparam logic [1:0] c_PC_PLUS4  = 2'b00;
    localparam logic [1:0] c_PC_BRANCH = 2'b01;
    localparam logic [1:0] c_PC_JUMP   = 2'b10;

    function automatic iclass_e classify(input logic [5:0] op);
        iclass_e cls;
        case (op)
            c_OP_RTYPE: cls = CL_RTYPE;
            c_OP_ADDI:  cls = CL_ADDI;
            c_OP_LW:    cls = CL_LW;
            c_OP_SW:    cls = CL_SW;
            c_OP_BEQ:   cls = CL_BEQ;
            c_OP_BNE:   cls = CL_BNE;
            c_OP_J:     cls = CL_J;
            default:    cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_seq_mem_wait_timer.sv
//------------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting on a memory ready; flags timeout at TIMEOUT-1.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);

    localparam int          c_CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int          c_LIMIT   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [c_CW-1:0] c_LIMIT_V = c_CW'(c_LIMIT);
    localparam logic        c_EN      = (TIMEOUT != 0);

    logic [c_CW-1:0] r_cnt;

    // Holding the count at zero outside a wait gives the clear-on-entry behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_active || i_ready) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign o_timeout = c_EN && i_active && !i_ready && (r_cnt == c_LIMIT_V);

endmodule

`default_nettype wire

// File: rtl/multicycle_seq.sv
//------------------------------------------------------------------------------
// multicycle_seq
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencing controller with halt/errors.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_seq
    import multicycle_seq_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             ir_we,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             busy,
    output logic             halted,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [CNT_W-1:0] retired
);

    state_e          r_state;
    state_e          w_next;
    iclass_e         r_cls;
    logic [CNT_W-1:0] r_retired;
    logic            r_err_illegal;
    logic            r_err_timeout;

    logic w_retire;
    logic w_set_illegal;
    logic w_set_timeout;
    logic w_wait_active;
    logic w_ready;
    logic w_timeout;

    assign w_wait_active = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_ready       = (r_state == S_FETCH) ? imem_ready : dmem_ready;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_active  (w_wait_active),
        .i_ready   (w_ready),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        imem_req      = 1'b0;
        dmem_rd       = 1'b0;
        dmem_wr       = 1'b0;
        pc_we         = 1'b0;
        pc_src        = c_PC_PLUS4;
        ir_we         = 1'b0;
        reg_we        = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src       = 1'b0;
        alu_op        = c_ALU_ADD;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = c_PC_PLUS4;
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next        = S_HALT;
                    w_set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                if (classify(opcode) == CL_ILLEGAL) begin
                    w_next        = S_HALT;
                    w_set_illegal = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_cls)
                    CL_RTYPE: begin
                        alu_op = c_ALU_FUNCT;
                        w_next = S_WB;
                    end
                    CL_ADDI: begin
                        alu_src = 1'b1;
                        w_next  = S_WB;
                    end
                    CL_LW, CL_SW: begin
                        alu_src = 1'b1;
                        w_next  = S_MEM;
                    end
                    CL_BEQ: begin
                        alu_op   = c_ALU_SUB;
                        pc_we    = zero;
                        pc_src   = c_PC_BRANCH;
                        w_retire = 1'b1;
                    end
                    CL_BNE: begin
                        alu_op   = c_ALU_SUB;
                        pc_we    = !zero;
                        pc_src   = c_PC_BRANCH;
                        w_retire = 1'b1;
                    end
                    CL_J: begin
                        pc_we    = 1'b1;
                        pc_src   = c_PC_JUMP;
                        w_retire = 1'b1;
                    end
                    default: w_next = S_HALT;
                endcase
            end
            S_MEM: begin
                alu_src = 1'b1;
                dmem_rd = (r_cls == CL_LW);
                dmem_wr = (r_cls == CL_SW);
                if (dmem_ready) begin
                    if (r_cls == CL_LW) w_next = S_WB;
                    else                w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next        = S_HALT;
                    w_set_timeout = 1'b1;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst    = (r_cls == CL_RTYPE);
                mem_to_reg = (r_cls == CL_LW);
                w_retire   = 1'b1;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_retire) w_next = halt_req ? S_IDLE : S_FETCH;
    end

    // Instruction class is captured in DECODE so EXEC/MEM/WB don't depend on the IR staying stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cls         <= CL_RTYPE;
            r_retired     <= '0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (r_state == S_DECODE) r_cls <= classify(opcode);
            if (w_retire)            r_retired <= r_retired + CNT_W'(1);
            if (w_set_illegal)       r_err_illegal <= 1'b1;
            if (w_set_timeout)       r_err_timeout <= 1'b1;
        end
    end

    assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted      = (r_state == S_HALT);
    assign err_illegal = r_err_illegal;
    assign err_timeout = r_err_timeout;
    assign retired     = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_seq.sv
//------------------------------------------------------------------------------
// tb_multicycle_seq
// Directed self-checking bench for multicycle_seq (TIMEOUT=4).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic [5:0]  opcode;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        dmem_rd;
    logic        dmem_wr;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        ir_we;
    logic        reg_we;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        busy;
    logic        halted;
    logic        err_illegal;
    logic        err_timeout;
    logic [31:0] retired;

    int r_checks = 0;
    int r_errors = 0;

    multicycle_seq #(
        .CNT_W   (32),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt_req    (halt_req),
        .opcode      (opcode),
        .zero        (zero),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .dmem_rd     (dmem_rd),
        .dmem_wr     (dmem_wr),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .ir_we       (ir_we),
        .reg_we      (reg_we),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .busy        (busy),
        .halted      (halted),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        start = 0; halt_req = 0; opcode = 6'h00; zero = 0;
        imem_ready = 1; dmem_ready = 0;
        rst_n = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_retired", retired, 0);
        chk("rst_errs", {err_illegal, err_timeout}, 0);
        do_reset();

        // R-type: FETCH DECODE EXEC WB
        start = 1; opcode = 6'h00;
        step(); start = 0; #1;
        chk("r_fetch_req", imem_req, 1);
        chk("r_fetch_irwe", {ir_we, pc_we, pc_src}, 4'b1100);
        step();
        chk("r_decode_busy", {busy, imem_req}, 2'b10);
        step();
        chk("r_exec_alu", {alu_op, alu_src}, 3'b100);
        step();
        chk("r_wb", {reg_we, reg_dst, mem_to_reg}, 3'b110);
        chk("r_wb_retired", retired, 0);
        step();
        chk("r_next_fetch", {imem_req, reg_we}, 2'b10);
        chk("r_retired", retired, 1);

        // lw with dmem_ready arriving on the 4th MEM cycle
        opcode = 6'h23;
        step();
        step();
        chk("lw_exec", {alu_op, alu_src}, 3'b001);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) begin dmem_ready = 1; #1; end
            chk($sformatf("lw_mem%0d_rd", i), {dmem_rd, dmem_wr, alu_src}, 3'b101);
        end
        step(); dmem_ready = 0; #1;
        chk("lw_wb", {reg_we, reg_dst, mem_to_reg, dmem_rd}, 4'b1010);
        chk("lw_wb_retired", retired, 1);
        step();
        chk("lw_retired", {imem_req, 31'(retired)}, {1'b1, 31'd2});

        // beq taken, then bne with zero=1 (not taken)
        opcode = 6'h04; zero = 1;
        step();
        step();
        chk("beq_exec", {pc_we, pc_src, alu_op}, 5'b10101);
        step();
        chk("beq_retired", {imem_req, 31'(retired)}, {1'b1, 31'd3});
        opcode = 6'h05;
        step();
        step();
        chk("bne_exec", {pc_we, pc_src, alu_op}, 5'b00101);
        step();
        chk("bne_retired", {imem_req, 31'(retired)}, {1'b1, 31'd4});

        // j with halt_req held -> IDLE after EXEC, then restart
        opcode = 6'h02; zero = 0; halt_req = 1;
        step();
        step();
        chk("j_exec", {pc_we, pc_src}, 3'b110);
        step(); halt_req = 0;
        chk("j_idle", {busy, halted, imem_req}, 3'b000);
        chk("j_retired", retired, 5);
        step();
        chk("idle_stays", busy, 0);
        start = 1; imem_ready = 0;
        step(); start = 0; #1;
        chk("resume_fetch", {imem_req, ir_we}, 2'b10);
        step();
        step();
        imem_ready = 1; opcode = 6'h2B; #1;
        chk("fetch_wait_ready", {imem_req, ir_we, halted}, 3'b110);

        // sw with dmem_ready never asserted -> timeout after 4 MEM cycles
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("sw_mem%0d_wr", i), {dmem_wr, dmem_rd, halted}, 3'b100);
        end
        step();
        chk("to_halt", {halted, busy, err_timeout, err_illegal}, 4'b1010);
        chk("to_dmem_wr", dmem_wr, 0);
        chk("to_retired", retired, 5);

        // reset in the middle of a fetch drops the request immediately
        do_reset();
        chk("reset_clears_err", {err_timeout, halted, 31'(retired)}, 0);
        start = 1; imem_ready = 0;
        step(); start = 0;
        chk("mid_fetch_req", imem_req, 1);
        rst_n = 0; #1;
        chk("async_rst_req", {imem_req, busy}, 2'b00);
        #2; rst_n = 1;

        // illegal opcode -> HALT after DECODE; start ignored until reset
        imem_ready = 1; opcode = 6'h3F; start = 1;
        step(); start = 0;
        step();
        chk("ill_decode", busy, 1);
        step();
        chk("ill_halt", {halted, busy, err_illegal, err_timeout}, 4'b1010);
        chk("ill_retired", retired, 0);
        start = 1;
        step();
        step(); start = 0;
        chk("ill_start_ignored", {halted, imem_req}, 2'b10);
        do_reset();
        #1;
        chk("ill_cleared", {halted, err_illegal}, 2'b00);

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule

`default_nettype wire
